// File: rtl/id_exe_stage.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// id_exe_stage
//
// ID->EXE pipeline register with integrated read-after-write hazard
// detection. Decoded instruction fields are registered into the execute
// stage. When a dependency cannot be resolved by forwarding, fetch/decode
// are stalled and a bubble is loaded into EXE.
//
// Build option:
//   FORWARD_EN  defined   : only load-use dependencies stall; ALU results are
//                           forwarded by the EXE forwarding unit.
//               undefined : any pending write to a source register in EXE or
//                           MEM stalls (mem_dest / mem_wb_en are used).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   freeze            global memory-wait hold (all EXE state holds)
//   flush             taken branch resolved in EXE (loads a bubble)
//   id_*              decoded instruction fields from the ID stage
//   mem_dest/_wb_en   destination of the instruction currently in MEM
//   hazard_stall      combinational: hold PC and IF/ID this cycle
//   e_*, src*_d_e     registered EXE-stage fields
//   stall_cnt         hazard bubbles inserted, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module id_exe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_src1,
   input  logic [REG_W-1:0]  id_src2,
   input  logic              id_two_src,
   input  logic [REG_W-1:0]  id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic [3:0]        id_exe_cmd,
   input  logic [DATA_W-1:0] id_val1,
   input  logic [DATA_W-1:0] id_val2,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [REG_W-1:0]  mem_dest,
   input  logic              mem_wb_en,
   output logic              hazard_stall,
   output logic              e_valid,
   output logic [REG_W-1:0]  src1_d_e,
   output logic [REG_W-1:0]  src2_d_e,
   output logic [REG_W-1:0]  e_dest,
   output logic              e_wb_en,
   output logic              e_mem_r_en,
   output logic              e_mem_w_en,
   output logic [3:0]        e_exe_cmd,
   output logic [DATA_W-1:0] e_val1,
   output logic [DATA_W-1:0] e_val2,
   output logic [DATA_W-1:0] e_pc,
   output logic [15:0]       stall_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [REG_W-1:0]  dest;
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [3:0]        exe_cmd;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [DATA_W-1:0] pc;
   } exe_fields_t;

   exe_fields_t r_exe;
   exe_fields_t w_id;
   logic [15:0] r_stall_cnt;

   assign w_id = '{
      valid:    id_valid,
      src1:     id_src1,
      src2:     id_src2,
      dest:     id_dest,
      wb_en:    id_wb_en,
      mem_r_en: id_mem_r_en,
      mem_w_en: id_mem_w_en,
      exe_cmd:  id_exe_cmd,
      val1:     id_val1,
      val2:     id_val2,
      pc:       id_pc
   };

   // Source matches against the EXE-stage destination. src2 only counts
   // when the instruction actually reads it.
   logic w_m1_e;
   logic w_m2_e;
   logic w_hazard;

   assign w_m1_e = id_valid & (id_src1 == r_exe.dest);
   assign w_m2_e = id_valid & id_two_src & (id_src2 == r_exe.dest);

`ifdef FORWARD_EN
   // Only a load in EXE cannot be forwarded in time: its data appears in MEM.
   assign w_hazard = r_exe.valid & r_exe.wb_en & r_exe.mem_r_en & (w_m1_e | w_m2_e);

   // MEM producer is irrelevant when forwarding covers it.
   logic w_unused_mem;
   assign w_unused_mem = ^{mem_dest, mem_wb_en};
`else
   logic w_m1_m;
   logic w_m2_m;

   assign w_m1_m   = id_valid & (id_src1 == mem_dest);
   assign w_m2_m   = id_valid & id_two_src & (id_src2 == mem_dest);
   assign w_hazard = (r_exe.valid & r_exe.wb_en & (w_m1_e | w_m2_e))
                   | (mem_wb_en & (w_m1_m | w_m2_m));
`endif

   // A flush discards the dependent instruction anyway, and a freeze holds
   // everything, so neither should hold the front end for a hazard.
   assign hazard_stall = w_hazard & ~flush & ~freeze;

   // Priority: reset > freeze (hold) > flush (bubble) > hazard (counted
   // bubble) > normal load.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exe       <= '0;
         r_stall_cnt <= '0;
      end else if (!freeze) begin
         if (flush) begin
            r_exe <= '0;
         end else if (w_hazard) begin
            r_exe <= '0;
            if (r_stall_cnt != 16'hFFFF) begin
               r_stall_cnt <= r_stall_cnt + 16'd1;
            end
         end else begin
            r_exe <= w_id;
         end
      end
   end

   assign e_valid    = r_exe.valid;
   assign src1_d_e   = r_exe.src1;
   assign src2_d_e   = r_exe.src2;
   assign e_dest     = r_exe.dest;
   assign e_wb_en    = r_exe.wb_en;
   assign e_mem_r_en = r_exe.mem_r_en;
   assign e_mem_w_en = r_exe.mem_w_en;
   assign e_exe_cmd  = r_exe.exe_cmd;
   assign e_val1     = r_exe.val1;
   assign e_val2     = r_exe.val2;
   assign e_pc       = r_exe.pc;
   assign stall_cnt  = r_stall_cnt;

endmodule
